// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a first-word-fall-through FIFO.
// It pops one byte per frame and sends it as a start bit, data bits LSB first, then stop bits.
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  input  logic                  fifo_not_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_en_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] shift, shift_next;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_next;
  logic [DIV_WIDTH-1:0]  baud_cnt, baud_cnt_next;
  logic [DIV_WIDTH-1:0]  div, div_next;
  logic                  tx, tx_next;

  logic wrap;
  logic frame_end;
  logic pop;

  // The divisor is latched at pop time, so it is at least 1 whenever a frame is active.
  assign wrap      = (baud_cnt == div - DIV_WIDTH'(1));
  assign frame_end = (state == STOP) && wrap && (bit_cnt == BIT_W'(STOP_BITS - 1));
  assign pop       = en_i && fifo_not_empty_i && ((state == IDLE) || frame_end);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      div      <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      shift    <= shift_next;
      bit_cnt  <= bit_cnt_next;
      baud_cnt <= baud_cnt_next;
      div      <= div_next;
      tx       <= tx_next;
    end
  end

  always_comb begin
    state_next    = state;
    shift_next    = shift;
    bit_cnt_next  = bit_cnt;
    baud_cnt_next = baud_cnt;
    div_next      = div;

    if (state != IDLE) begin
      baud_cnt_next = wrap ? '0 : baud_cnt + DIV_WIDTH'(1);
    end

    case (state)
      START: begin
        if (wrap) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (wrap) begin
          shift_next = shift >> 1;
          if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
            state_next   = STOP;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (wrap) begin
          if (frame_end) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: ;
    endcase

    // A pop in the last stop cycle chains straight into the next start bit.
    if (pop) begin
      state_next    = START;
      shift_next    = fifo_data_i;
      bit_cnt_next  = '0;
      baud_cnt_next = '0;
      div_next      = (baud_div_i == '0) ? DIV_WIDTH'(1) : baud_div_i;
    end

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign fifo_rd_en_o = pop && !rst_i;
  assign tx_o         = tx;
  assign busy_o       = (state != IDLE);
  assign done_o       = frame_end;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Scoreboard bench: each expected pop queues the per-cycle line waveform of its frame,
// and a negedge monitor compares the DUT against that queue.
module tb_uart_tx_fifo_drain;

  localparam int DW    = 8;
  localparam int DIVW  = 16;
  localparam int SB    = 1;
  localparam int FRAME = 1 + DW + SB;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic [DIVW-1:0] baud = 16'd4;
  logic            fifo_ne = 1'b0;
  logic [DW-1:0]   fifo_data = '0;
  logic            rd_en, tx, busy, done;

  uart_tx_fifo_drain #(.DATA_WIDTH(DW), .DIV_WIDTH(DIVW), .STOP_BITS(SB)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .baud_div_i(baud),
    .fifo_not_empty_i(fifo_ne), .fifo_data_i(fifo_data),
    .fifo_rd_en_o(rd_en), .tx_o(tx), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic txv; logic donev;} exp_t;

  exp_t      exp_q[$];
  logic [7:0] fifo_q[$];
  int        compared = 0;
  int        mismatched = 0;
  int        pop_count = 0;
  int        done_count = 0;
  bit        popped = 0;

  task automatic chk(input string name, input int act, input int expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor / scoreboard
  exp_t        it;
  bit          in_frame, last, pop_exp, bitv;
  int          n;
  logic [7:0]  byte_v;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", rd_en, 0);
      exp_q.delete();
      popped = 0;
    end else begin
      in_frame = exp_q.size() > 0;
      last = 0;
      if (in_frame) begin
        it = exp_q.pop_front();
        chk("tx", tx, it.txv);
        chk("busy", busy, 1);
        chk("done", done, it.donev);
        last = it.donev;
        if (done) done_count++;
      end else begin
        chk("idle_tx", tx, 1);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
      end
      pop_exp = en && fifo_ne && (!in_frame || last);
      chk("rd_en", rd_en, pop_exp);
      popped = rd_en;
      if (rd_en) pop_count++;
      if (pop_exp) begin
        n = (baud == 0) ? 1 : int'(baud);
        byte_v = fifo_data;
        for (int k = 0; k < FRAME; k++) begin
          if (k == 0) bitv = 0;
          else if (k <= DW) bitv = byte_v[k-1];
          else bitv = 1;
          for (int r = 0; r < n; r++)
            exp_q.push_back('{txv: bitv, donev: (k == FRAME-1 && r == n-1)});
        end
      end
    end
  end

  task automatic drive();
    fifo_ne = fifo_q.size() > 0;
    fifo_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (popped) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      popped = 0;
    end
    drive();
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    drive();
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((exp_q.size() > 0 || (en && fifo_ne)) && c < budget) begin
      step();
      c++;
    end
    if (c >= budget) begin
      mismatched++;
      $display("FAIL wait_idle: timeout after %0d cycles, expected drain", budget);
    end
    step();
  endtask

  initial begin
    int pc0;
    repeat (3) step();
    rst = 0;
    step();

    // single byte 0xA5, N=4
    baud = 4; en = 1; pc0 = pop_count; done_count = 0;
    push(8'hA5);
    wait_idle(200);
    chk("t1_pops", pop_count - pc0, 1);
    chk("t1_dones", done_count, 1);

    // three bytes back to back, N=2
    baud = 2; pc0 = pop_count;
    push(8'h00); push(8'hFF); push(8'h3C);
    wait_idle(300);
    chk("t2_pops", pop_count - pc0, 3);

    // empty FIFO, enabled
    pc0 = pop_count;
    repeat (100) step();
    chk("t3_pops", pop_count - pc0, 0);

    // enable dropped mid-frame with two bytes queued
    baud = 4;
    push(8'h5A); push(8'hC3);
    repeat (10) step();
    en = 0;
    wait_idle(200);
    chk("t4_held", fifo_q.size(), 1);
    en = 1;
    wait_idle(200);

    // reset during a data bit, with another byte waiting
    push(8'h00);
    repeat (12) step();
    push(8'h81);
    rst = 1;
    #1;
    chk("t5_async_tx", tx, 1);
    chk("t5_async_busy", busy, 0);
    repeat (2) step();
    rst = 0;
    wait_idle(200);

    // divisor 0 then change mid-frame
    baud = 0; done_count = 0;
    push(8'h55); push(8'h55);
    en = 0;
    step();
    en = 1;
    step();
    repeat (4) step();
    baud = 8;
    wait_idle(300);
    chk("t6_dones", done_count, 2);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0 && fifo_q.size() < 8) push(8'($urandom));
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) baud = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        rst = 1;
        step();
        rst = 0;
      end
      step();
    end
    en = 1;
    wait_idle(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
